ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv_pkg.sv | 46 ++++
 rtl/ex_muldiv_signfix.sv | 48 ++++
 rtl/ex_muldiv.sv | 162 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: result class, op codes,
// FSM states and small op-classification helpers.
package ex_muldiv_pkg;

    localparam logic [2:0] EXE_RES_MULDIV = 3'b101;

    localparam logic [7:0] EXE_MUL_OP    = 8'h58;
    localparam logic [7:0] EXE_MULH_OP   = 8'h59;
    localparam logic [7:0] EXE_MULHSU_OP = 8'h5A;
    localparam logic [7:0] EXE_MULHU_OP  = 8'h5B;
    localparam logic [7:0] EXE_DIV_OP    = 8'h5C;
    localparam logic [7:0] EXE_DIVU_OP   = 8'h5D;
    localparam logic [7:0] EXE_REM_OP    = 8'h5E;
    localparam logic [7:0] EXE_REMU_OP   = 8'h5F;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic is_mul_op(input logic [7:0] op);
        return op inside {EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP};
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return op inside {EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};
    endfunction

    function automatic logic is_rem_op(input logic [7:0] op);
        return op inside {EXE_REM_OP, EXE_REMU_OP};
    endfunction

    function automatic logic is_sdiv_op(input logic [7:0] op);
        return op inside {EXE_DIV_OP, EXE_REM_OP};
    endfunction

    function automatic logic rs1_signed(input logic [7:0] op);
        return op inside {EXE_MULH_OP, EXE_MULHSU_OP, EXE_DIV_OP, EXE_REM_OP};
    endfunction

    function automatic logic rs2_signed(input logic [7:0] op);
        return op inside {EXE_MULH_OP, EXE_DIV_OP, EXE_REM_OP};
    endfunction

endpackage

// File: rtl/ex_muldiv_signfix.sv
// Sign handling for the muldiv unit: operand magnitudes and result-negate flag
// on entry, and sign-corrected result selection on exit.
module ex_muldiv_signfix
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [7:0]        aluop,
    input  logic [XLEN-1:0]   reg1,
    input  logic [XLEN-1:0]   reg2,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              neg,
    input  logic [7:0]        op_q,
    input  logic              neg_q,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   res
);

    logic              sgn1;
    logic              sgn2;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        sgn1 = rs1_signed(aluop) && reg1[XLEN-1];
        sgn2 = rs2_signed(aluop) && reg2[XLEN-1];
        mag1 = sgn1 ? -reg1 : reg1;
        mag2 = sgn2 ? -reg2 : reg2;
        // remainder follows the dividend; product and quotient follow the sign mix
        neg  = is_rem_op(aluop) ? sgn1 : (sgn1 ^ sgn2);
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            EXE_MUL_OP:                              res = prod[XLEN-1:0];
            EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: res = prod[2*XLEN-1:XLEN];
            EXE_DIV_OP, EXE_DIVU_OP:                 res = quo;
            EXE_REM_OP, EXE_REMU_OP:                 res = rem;
            default:                                 res = prod[XLEN-1:0];
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execution unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, stalling the pipeline while it works.
//
// state   | meaning
// MD_IDLE | waiting for an M-op; latches operands or resolves div special cases
// MD_CALC | one iteration per cycle, counter 0..XLEN-1
// MD_DONE | result_o valid for one cycle, pipeline released
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [7:0]      aluop_i,
    input  logic [2:0]      alusel_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            stallreq_o,
    output logic            busy_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q;
    md_state_e         state_nxt;
    logic [CNT_W-1:0]  counter;
    logic [7:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opd_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;

    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              neg;
    logic [XLEN-1:0]   fix_res;

    logic              start;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              last_iter;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;

    ex_muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .aluop (aluop_i),
        .reg1  (reg1_i),
        .reg2  (reg2_i),
        .mag1  (mag1),
        .mag2  (mag2),
        .neg   (neg),
        .op_q  (op_q),
        .neg_q (neg_q),
        .acc   (acc_nxt),
        .res   (fix_res)
    );

    always_comb begin
        start       = (alusel_i == EXE_RES_MULDIV) && !flush;
        div_zero    = is_div_op(aluop_i) && (reg2_i == '0);
        div_ovf     = is_sdiv_op(aluop_i) && (reg1_i == INT_MIN) && (reg2_i == '1);
        special     = div_zero || div_ovf;
        if (div_zero)
            special_res = is_rem_op(aluop_i) ? reg1_i : '1;
        else
            special_res = is_rem_op(aluop_i) ? '0 : INT_MIN;
        last_iter   = (counter == CNT_W'(XLEN-1));
    end

    // Multiply keeps {partial, multiplier} and shifts right; divide keeps
    // {remainder, dividend/quotient} and shifts left.
    always_comb begin
        acc_nxt = acc;
        add_sum = '0;
        rem_sh  = '0;
        diff    = '0;
        if (is_mul_op(op_q)) begin
            add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd_q} : '0);
            acc_nxt = {add_sum, acc[XLEN-1:1]};
        end else begin
            rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            diff   = rem_sh - {1'b0, opd_q};
            if (!diff[XLEN])
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= MD_IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            MD_IDLE: begin
                if (start)
                    state_nxt = special ? MD_DONE : MD_CALC;
            end
            MD_CALC: begin
                if (flush)
                    state_nxt = MD_IDLE;
                else if (last_iter)
                    state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = !rst && (((state_q == MD_IDLE) && start) || (state_q == MD_CALC));
        busy_o     = (state_q != MD_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter        <= '0;
            op_q           <= '0;
            neg_q          <= 1'b0;
            opd_q          <= '0;
            acc            <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= (state_nxt == MD_DONE);
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        counter <= '0;
                        op_q    <= aluop_i;
                        neg_q   <= neg;
                        opd_q   <= is_mul_op(aluop_i) ? mag1 : mag2;
                        acc     <= {{XLEN{1'b0}}, (is_mul_op(aluop_i) ? mag2 : mag1)};
                        if (special)
                            result_o <= special_res;
                    end
                end
                MD_CALC: begin
                    acc     <= acc_nxt;
                    counter <= counter + 1'b1;
                    if (last_iter && !flush)
                        result_o <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed results, latency and stall
// shape per op, special divide cases, flush and async reset.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam logic [2:0] RES_NONE = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] result;
    logic        result_valid;
    logic        stallreq;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .aluop_i        (aluop),
        .alusel_i       (alusel),
        .reg1_i         (reg1),
        .reg2_i         (reg2),
        .result_o       (result),
        .result_valid_o (result_valid),
        .stallreq_o     (stallreq),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents an op at cycle 0, holds it until the valid cycle, checks result,
    // cycle of the valid pulse and that stall stayed high until then.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        int stall_bad;
        bit seen;
        @(posedge clk);
        #1;
        alusel = EXE_RES_MULDIV;
        aluop  = op;
        reg1   = a;
        reg2   = b;
        cyc = 0;
        stall_bad = 0;
        seen = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1;
                check({tag, " result"}, result, exp);
                check({tag, " stall in done"}, stallreq, 1'b0);
            end else begin
                if (!stallreq)
                    stall_bad++;
                if (cyc == 1) begin
                    reg1 = ~a;
                    reg2 = b ^ 32'h5A5A_5A5A;
                end
                cyc++;
            end
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " stall gaps"}, stall_bad, 0);
    endtask

    initial begin
        int vp;
        rst    = 1'b1;
        flush  = 1'b0;
        alusel = EXE_RES_MULDIV;
        aluop  = EXE_MUL_OP;
        reg1   = 32'd0;
        reg2   = 32'd0;
        #12;
        check("reset stall", stallreq, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset valid", result_valid, 1'b0);
        check("reset result", result, 32'h0);
        alusel = RES_NONE;
        @(negedge clk);
        rst = 1'b0;

        @(posedge clk);
        #1;
        aluop = EXE_MUL_OP;
        reg1  = 32'd5;
        reg2  = 32'd6;
        repeat (2) @(negedge clk);
        check("non-M stall", stallreq, 1'b0);
        check("non-M busy", busy, 1'b0);

        @(posedge clk);
        #1;
        alusel = EXE_RES_MULDIV;
        flush  = 1'b1;
        @(negedge clk);
        check("idle flush stall", stallreq, 1'b0);
        @(posedge clk);
        #1;
        flush  = 1'b0;
        alusel = RES_NONE;
        @(negedge clk);
        check("idle flush busy", busy, 1'b0);

        run_op("MUL",    EXE_MUL_OP,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULHU",  EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULH",   EXE_MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("MULHSU", EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("DIV",    EXE_DIV_OP,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("REM",    EXE_REM_OP,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("DIVU",   EXE_DIVU_OP,   32'd7,        32'd2,        32'd3,        33);
        run_op("REMU",   EXE_REMU_OP,   32'd7,        32'd2,        32'd1,        33);
        run_op("DIV0",   EXE_DIV_OP,    32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("REM0",   EXE_REM_OP,    32'd5,        32'd0,        32'd5,        1);
        run_op("REMU0",  EXE_REMU_OP,   32'd9,        32'd0,        32'd9,        1);
        run_op("DIVOVF", EXE_DIV_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REMOVF", EXE_REM_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // flush while the counter reads 10 (cycle 11)
        vp = 0;
        @(posedge clk);
        #1;
        alusel = EXE_RES_MULDIV;
        aluop  = EXE_MULHU_OP;
        reg1   = 32'h1234_5678;
        reg2   = 32'h9ABC_DEF0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (result_valid)
                vp++;
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush busy before", busy, 1'b1);
        if (result_valid)
            vp++;
        @(posedge clk);
        #1;
        flush  = 1'b0;
        alusel = RES_NONE;
        @(negedge clk);
        check("flush stall after", stallreq, 1'b0);
        check("flush busy after", busy, 1'b0);
        check("flush valid after", result_valid, 1'b0);
        check("flush valid pulses", vp, 0);
        run_op("MUL after flush", EXE_MUL_OP, 32'd3, 32'd4, 32'd12, 33);

        // async reset mid-CALC
        @(posedge clk);
        #1;
        alusel = EXE_RES_MULDIV;
        aluop  = EXE_DIVU_OP;
        reg1   = 32'd1000;
        reg2   = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset busy", busy, 1'b0);
        check("async reset valid", result_valid, 1'b0);
        check("async reset stall", stallreq, 1'b0);
        alusel = RES_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op("DIVU after rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU after rst", EXE_REMU_OP, 32'd100, 32'd7, 32'd2, 33);
        @(posedge clk);
        #1;
        alusel = RES_NONE;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
